scif_activation_ctrl: RTL and testbench

Sequencer for the SCIF smart-card interface: performs ISO7816-style cold activation, warm reset and deactivation of the card contacts (VCC, CLK, RST, I/O) and supervises the Answer-To-Reset window. It sits between the SCIF register block and the pad/receiver logic. It gates the receiver enable and reports state and sticky errors back to software.

---
 rtl/scif_ctrl_pkg.sv | 50 +++++
 rtl/scif_activation_ctrl_if.sv | 41 ++++
 rtl/scif_phase_timer.sv | 39 +++
 rtl/scif_activation_ctrl.sv | 121 ++++++++++++
 tb/tb_scif_activation_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scif_ctrl_pkg.sv
// Shared types for the SCIF activation sequencer: state encoding and
// per-state contact output vectors.
package scif_ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_VCC_UP   = 4'd1,
    ST_CLK_RST  = 4'd2,
    ST_ATR_WAIT = 4'd3,
    ST_ACTIVE   = 4'd4,
    ST_D_RST    = 4'd5,
    ST_D_CLK    = 4'd6,
    ST_D_IO     = 4'd7
  } state_t;

  typedef struct packed {
    logic vcc;
    logic clk_en;
    logic rst;
    logic io_en;
    logic rx_en;
  } contacts_t;

  localparam contacts_t CT_IDLE     = 5'b00000;
  localparam contacts_t CT_VCC_UP   = 5'b10000;
  localparam contacts_t CT_CLK_RST  = 5'b11011;
  localparam contacts_t CT_ATR_WAIT = 5'b11111;
  localparam contacts_t CT_ACTIVE   = 5'b11111;
  localparam contacts_t CT_D_RST    = 5'b11010;
  localparam contacts_t CT_D_CLK    = 5'b10010;
  localparam contacts_t CT_D_IO     = 5'b10000;

  function automatic contacts_t contacts_of(input state_t s);
    contacts_t c;
    case (s)
      ST_VCC_UP:   c = CT_VCC_UP;
      ST_CLK_RST:  c = CT_CLK_RST;
      ST_ATR_WAIT: c = CT_ATR_WAIT;
      ST_ACTIVE:   c = CT_ACTIVE;
      ST_D_RST:    c = CT_D_RST;
      ST_D_CLK:    c = CT_D_CLK;
      ST_D_IO:     c = CT_D_IO;
      default:     c = CT_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/scif_activation_ctrl_if.sv
// Control, timing and contact signals between the SCIF register block,
// the activation sequencer and the pad logic.
interface scif_activation_ctrl_if
  import scif_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 24
);
  logic               start_i;
  logic               warm_i;
  logic               stop_i;
  logic               card_detect_i;
  logic               rx_valid_i;
  logic               err_clr_i;
  logic [CNT_W-1:0]   t_vcc_i;
  logic [CNT_W-1:0]   t_rst_i;
  logic [CNT_W-1:0]   t_atr_i;
  logic [CNT_W-1:0]   t_gap_i;
  logic               card_vcc_o;
  logic               card_clk_en_o;
  logic               card_rst_o;
  logic               card_io_en_o;
  logic               rx_en_o;
  logic [STATE_W-1:0] state_o;
  logic               active_o;
  logic               err_no_atr_o;
  logic               err_removed_o;

  modport master (
    output start_i, warm_i, stop_i, card_detect_i, rx_valid_i, err_clr_i,
           t_vcc_i, t_rst_i, t_atr_i, t_gap_i,
    input  card_vcc_o, card_clk_en_o, card_rst_o, card_io_en_o, rx_en_o,
           state_o, active_o, err_no_atr_o, err_removed_o
  );

  modport slave (
    input  start_i, warm_i, stop_i, card_detect_i, rx_valid_i, err_clr_i,
           t_vcc_i, t_rst_i, t_atr_i, t_gap_i,
    output card_vcc_o, card_clk_en_o, card_rst_o, card_io_en_o, rx_en_o,
           state_o, active_o, err_no_atr_o, err_removed_o
  );
endinterface

// File: rtl/scif_phase_timer.sv
// Loadable down-counter timing each sequencer phase; zero flag is registered
// alongside the count so the FSM sees it without extra decode depth.
module scif_phase_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             zero_q;

  // Load wins; otherwise count down and hold at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= (count_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/scif_activation_ctrl.sv
// SCIF card activation / warm reset / deactivation sequencer with ATR
// supervision and sticky error reporting.
module scif_activation_ctrl
  import scif_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  scif_activation_ctrl_if.slave  bus
);

  state_t           state_q;
  state_t           state_d;
  logic             set_no_atr;
  logic             set_removed;
  logic             timer_zero;
  logic             timer_load;
  logic [CNT_W-1:0] t_sel;
  logic [CNT_W-1:0] t_load_val;
  contacts_t        contacts_q;
  logic             active_q;
  logic             err_no_atr_q;
  logic             err_removed_q;

  // Next state: removal > stop > rx_valid/warm > timer expiry
  always_comb begin
    state_d     = state_q;
    set_no_atr  = 1'b0;
    set_removed = 1'b0;
    if ((state_q != ST_IDLE) && !bus.card_detect_i) begin
      set_removed = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i && bus.card_detect_i) state_d = ST_VCC_UP;
      end
      ST_VCC_UP: begin
        if (!bus.card_detect_i || bus.stop_i) state_d = ST_D_RST;
        else if (timer_zero)                  state_d = ST_CLK_RST;
      end
      ST_CLK_RST: begin
        if (!bus.card_detect_i || bus.stop_i) state_d = ST_D_RST;
        else if (timer_zero)                  state_d = ST_ATR_WAIT;
      end
      ST_ATR_WAIT: begin
        if (!bus.card_detect_i || bus.stop_i) begin
          state_d = ST_D_RST;
        end else if (bus.rx_valid_i) begin
          state_d = ST_ACTIVE;
        end else if (timer_zero) begin
          state_d    = ST_D_RST;
          set_no_atr = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!bus.card_detect_i || bus.stop_i) state_d = ST_D_RST;
        else if (bus.warm_i)                  state_d = ST_CLK_RST;
      end
      ST_D_RST: if (timer_zero) state_d = ST_D_CLK;
      ST_D_CLK: if (timer_zero) state_d = ST_D_IO;
      ST_D_IO:  if (timer_zero) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Every state change reloads the timer with max(T,1)-1 for the new phase
  always_comb begin
    t_sel = '0;
    case (state_d)
      ST_VCC_UP:                   t_sel = bus.t_vcc_i;
      ST_CLK_RST:                  t_sel = bus.t_rst_i;
      ST_ATR_WAIT:                 t_sel = bus.t_atr_i;
      ST_D_RST, ST_D_CLK, ST_D_IO: t_sel = bus.t_gap_i;
      default:                     t_sel = '0;
    endcase
    t_load_val = (t_sel == '0) ? '0 : (t_sel - CNT_W'(1));
    timer_load = (state_d != state_q);
  end

  scif_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (timer_load),
    .value_i (t_load_val),
    .zero_o  (timer_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Outputs decoded from the next state so they move with the state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      contacts_q    <= CT_IDLE;
      active_q      <= 1'b0;
      err_no_atr_q  <= 1'b0;
      err_removed_q <= 1'b0;
    end else begin
      contacts_q    <= contacts_of(state_d);
      active_q      <= (state_d == ST_ACTIVE);
      err_no_atr_q  <= set_no_atr  | (err_no_atr_q  & ~bus.err_clr_i);
      err_removed_q <= set_removed | (err_removed_q & ~bus.err_clr_i);
    end
  end

  assign bus.card_vcc_o    = contacts_q.vcc;
  assign bus.card_clk_en_o = contacts_q.clk_en;
  assign bus.card_rst_o    = contacts_q.rst;
  assign bus.card_io_en_o  = contacts_q.io_en;
  assign bus.rx_en_o       = contacts_q.rx_en;
  assign bus.state_o       = state_q;
  assign bus.active_o      = active_q;
  assign bus.err_no_atr_o  = err_no_atr_q;
  assign bus.err_removed_o = err_removed_q;

endmodule

// File: tb/tb_scif_activation_ctrl.sv
// Directed bench for scif_activation_ctrl: per-cycle vector table plus
// timed sequences for activation, ATR timeout, removal, warm reset and stop.
module tb_scif_activation_ctrl;

  localparam int unsigned CNT_W = 24;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  scif_activation_ctrl_if #(.CNT_W(CNT_W)) bus ();

  scif_activation_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct packed {
    logic       start;
    logic       warm;
    logic       stop;
    logic       det;
    logic       rx;
    logic       clr;
    logic [3:0] st;
    logic       na;
    logic       rm;
  } vec_t;

  localparam int NVEC = 24;
  vec_t tbl [NVEC];

  int total = 0;
  int bad   = 0;
  int rise [8];
  int fall [8];
  int ent  [16];

  // {state[11:8], vcc, clk, rst, io, rx, active, err_no_atr, err_removed}
  function automatic logic [11:0] obs();
    return {bus.state_o, bus.card_vcc_o, bus.card_clk_en_o, bus.card_rst_o,
            bus.card_io_en_o, bus.rx_en_o, bus.active_o, bus.err_no_atr_o,
            bus.err_removed_o};
  endfunction

  function automatic logic [11:0] expv(input logic [3:0] st, input logic na,
                                       input logic rm);
    logic [4:0] ct;
    case (st)
      4'd1:       ct = 5'b10000;
      4'd2:       ct = 5'b11011;
      4'd3, 4'd4: ct = 5'b11111;
      4'd5:       ct = 5'b11010;
      4'd6:       ct = 5'b10010;
      4'd7:       ct = 5'b10000;
      default:    ct = 5'b00000;
    endcase
    return {st, ct, (st == 4'd4), na, rm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.start_i       = 1'b0;
    bus.warm_i        = 1'b0;
    bus.stop_i        = 1'b0;
    bus.card_detect_i = 1'b1;
    bus.rx_valid_i    = 1'b0;
    bus.err_clr_i     = 1'b0;
  endtask

  task automatic set_t(input int a, input int b, input int c, input int g);
    bus.t_vcc_i = CNT_W'(a);
    bus.t_rst_i = CNT_W'(b);
    bus.t_atr_i = CNT_W'(c);
    bus.t_gap_i = CNT_W'(g);
  endtask

  task automatic do_reset();
    set_idle();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Runs n cycles; pulse inputs fire in the iteration given (0 = never),
  // card removed from dr_at onward. Records last edge/entry times.
  task automatic run_seq(input int n, input int st_at, input int rx_at,
                         input int wm_at, input int sp_at, input int dr_at,
                         input int cl_at);
    logic [11:0] prev;
    logic [11:0] cur;
    for (int b = 0; b < 8; b++) begin
      rise[b] = -1;
      fall[b] = -1;
    end
    for (int s = 0; s < 16; s++) ent[s] = -1;
    prev = obs();
    for (int c = 1; c <= n; c++) begin
      bus.start_i       = (c == st_at);
      bus.rx_valid_i    = (c == rx_at);
      bus.warm_i        = (c == wm_at);
      bus.stop_i        = (c == sp_at);
      bus.card_detect_i = !((dr_at > 0) && (c >= dr_at));
      bus.err_clr_i     = (c == cl_at);
      @(posedge clk_i);
      #1;
      cur = obs();
      for (int b = 0; b < 8; b++) begin
        if (!prev[b] && cur[b]) rise[b] = c;
        if (prev[b] && !cur[b]) fall[b] = c;
      end
      if (cur[11:8] != prev[11:8]) ent[cur[11:8]] = c;
      prev = cur;
    end
    set_idle();
  endtask

  initial begin
    tbl[0]  = {6'b000100, 4'd0, 1'b0, 1'b0};
    tbl[1]  = {6'b100000, 4'd0, 1'b0, 1'b0};
    tbl[2]  = {6'b010100, 4'd0, 1'b0, 1'b0};
    tbl[3]  = {6'b100100, 4'd1, 1'b0, 1'b0};
    tbl[4]  = {6'b000100, 4'd1, 1'b0, 1'b0};
    tbl[5]  = {6'b000100, 4'd2, 1'b0, 1'b0};
    tbl[6]  = {6'b000100, 4'd2, 1'b0, 1'b0};
    tbl[7]  = {6'b000100, 4'd2, 1'b0, 1'b0};
    tbl[8]  = {6'b000100, 4'd3, 1'b0, 1'b0};
    tbl[9]  = {6'b000110, 4'd4, 1'b0, 1'b0};
    tbl[10] = {6'b100100, 4'd4, 1'b0, 1'b0};
    tbl[11] = {6'b010100, 4'd2, 1'b0, 1'b0};
    tbl[12] = {6'b000100, 4'd2, 1'b0, 1'b0};
    tbl[13] = {6'b001100, 4'd5, 1'b0, 1'b0};
    tbl[14] = {6'b010000, 4'd5, 1'b0, 1'b1};
    tbl[15] = {6'b000100, 4'd6, 1'b0, 1'b1};
    tbl[16] = {6'b001100, 4'd6, 1'b0, 1'b1};
    tbl[17] = {6'b000101, 4'd7, 1'b0, 1'b0};
    tbl[18] = {6'b000100, 4'd7, 1'b0, 1'b0};
    tbl[19] = {6'b000100, 4'd0, 1'b0, 1'b0};
    tbl[20] = {6'b100100, 4'd1, 1'b0, 1'b0};
    tbl[21] = {6'b001000, 4'd5, 1'b0, 1'b1};
    tbl[22] = {6'b000001, 4'd5, 1'b0, 1'b1};
    tbl[23] = {6'b000101, 4'd6, 1'b0, 1'b0};

    rst_i = 1'b1;
    set_idle();
    set_t(2, 3, 4, 2);
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_state", 32'(obs()), 32'(expv(4'd0, 1'b0, 1'b0)));
    rst_i = 1'b0;

    // Per-cycle vectors with short phase times
    for (int i = 0; i < NVEC; i++) begin
      bus.start_i       = tbl[i].start;
      bus.warm_i        = tbl[i].warm;
      bus.stop_i        = tbl[i].stop;
      bus.card_detect_i = tbl[i].det;
      bus.rx_valid_i    = tbl[i].rx;
      bus.err_clr_i     = tbl[i].clr;
      @(posedge clk_i);
      #1;
      chk($sformatf("vec%0d", i), 32'(obs()),
          32'(expv(tbl[i].st, tbl[i].na, tbl[i].rm)));
    end

    // Cold activation with ATR byte 20 cycles after RST rises
    do_reset();
    set_t(4, 10, 100, 3);
    run_seq(40, 1, 36, 0, 0, 0, 0);
    chk("cold_vcc_rise", rise[7], 1);
    chk("cold_clk_rise", rise[6], 5);
    chk("cold_rst_rise", rise[5], 15);
    chk("cold_active_rise", rise[2], 36);
    chk("cold_no_errors", 32'(obs() & 12'h003), 0);

    // ATR timeout and ordered deactivation
    do_reset();
    set_t(4, 10, 50, 3);
    run_seq(80, 1, 0, 0, 0, 0, 0);
    chk("noatr_rst_rise", rise[5], 15);
    chk("noatr_err_set", rise[1], 65);
    chk("noatr_rst_fall", fall[5], 65);
    chk("noatr_clk_fall", fall[6], 68);
    chk("noatr_io_fall", fall[4], 71);
    chk("noatr_vcc_fall", fall[7], 74);
    chk("noatr_idle", ent[0], 74);
    run_seq(3, 1, 0, 0, 0, 0, 0);
    chk("restart_vcc_rise", rise[7], 1);
    chk("restart_err_kept", 32'(obs() & 12'h002), 32'h2);
    run_seq(2, 0, 0, 0, 0, 0, 1);
    chk("errclr_no_atr", 32'(obs() & 12'h002), 0);

    // Removal coincident with warm reset in ACTIVE
    do_reset();
    set_t(4, 10, 100, 3);
    run_seq(55, 1, 36, 40, 0, 40, 0);
    chk("rem_active_rise", rise[2], 36);
    chk("rem_err_set", rise[0], 40);
    chk("rem_drst_entry", ent[5], 40);
    chk("rem_no_warm", ent[2], 5);
    chk("rem_rst_fall", fall[5], 40);
    chk("rem_clk_fall", fall[6], 43);
    chk("rem_io_fall", fall[4], 46);
    chk("rem_vcc_fall", fall[7], 49);
    chk("rem_idle", ent[0], 49);

    // Warm reset holds RST low for t_rst while VCC/CLK stay up
    do_reset();
    set_t(4, 8, 100, 3);
    run_seq(35, 1, 20, 25, 0, 0, 0);
    chk("warm_rst_fall", fall[5], 25);
    chk("warm_rst_rise", rise[5], 33);
    chk("warm_atr_entry", ent[3], 33);
    chk("warm_active_fall", fall[2], 25);
    chk("warm_clk_held", fall[6], -1);
    chk("warm_vcc_held", fall[7], -1);
    run_seq(105, 0, 0, 0, 0, 0, 0);
    chk("warm_fresh_timeout", rise[1], 98);

    // Stop in VCC_UP with all phase times zero
    do_reset();
    set_t(0, 0, 0, 0);
    run_seq(8, 1, 0, 0, 2, 0, 0);
    chk("zero_vccup_entry", ent[1], 1);
    chk("zero_drst_entry", ent[5], 2);
    chk("zero_dclk_entry", ent[6], 3);
    chk("zero_dio_entry", ent[7], 4);
    chk("zero_idle_entry", ent[0], 5);
    chk("zero_vcc_fall", fall[7], 5);
    chk("zero_no_clkrst", ent[2], -1);

    // Asynchronous reset in ATR_WAIT
    do_reset();
    set_t(4, 10, 100, 3);
    run_seq(20, 1, 0, 0, 0, 0, 0);
    chk("async_pre_state", 32'(obs()), 32'(expv(4'd3, 1'b0, 1'b0)));
    rst_i = 1'b1;
    #2;
    chk("async_rst_outputs", 32'(obs()), 0);
    #1;
    rst_i = 1'b0;

    // err_clr coincident with ATR timeout: set wins
    do_reset();
    set_t(4, 10, 6, 3);
    run_seq(23, 1, 0, 0, 0, 0, 21);
    chk("clrset_err_rise", rise[1], 21);
    chk("clrset_drst_entry", ent[5], 21);
    chk("clrset_err_kept", 32'(obs() & 12'h002), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
